// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control unit.
//   - state_t : 4-bit state encoding (also driven out on State for debug)
//   - OP_*    : opcode constants for the six supported instruction classes
//   - ALUOP_*, SRCB_*, PCSRC_* : datapath mux / ALU control codes
//   - ctrl_t  : the control word produced by the state decoder
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic       illegal;
    } ctrl_t;

    function automatic logic op_known(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state decoder: current state -> datapath control word.
// Ports:
//   state     in  4  current state code
//   op        in  6  IR opcode, used only to flag an illegal opcode in DECODE
//   mem_ready in  1  memory handshake, qualifies IR/PC loads in FETCH
//   ctrl      out    control word (all fields 0 unless set for the state)
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.memread = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                // IR and PC load only on the cycle the instruction word arrives.
                ctrl.irwrite = mem_ready;
                ctrl.pcwrite = mem_ready;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                ctrl.alusrcb = SRCB_IMM_SH2;
                ctrl.illegal = !op_known(op);
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.memwrite = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_B;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca  = 1'b1;
                ctrl.alusrcb  = SRCB_B;
                ctrl.aluop    = ALUOP_SUB;
                ctrl.pcsource = PCSRC_ALUOUT;
                ctrl.branch   = 1'b1;
            end
            S_JUMP: begin
                ctrl.pcwrite  = 1'b1;
                ctrl.pcsource = PCSRC_JUMP;
            end
            S_ADDIWB: begin
                ctrl.regwrite = 1'b1;
            end
            default: ; // S_RESET, S_HALT and unused codes: everything 0
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle main control FSM for the 10-instruction MIPS core.
// Ports:
//   CLK, Rst (async active-low)      clock / reset
//   Op, Zero, Mem_Ready              opcode, ALU zero flag, memory handshake
//   PCEn .. PCSource                 datapath enables and mux selects
//   State                            current state (debug)
//   Illegal                          one-cycle pulse on an unknown opcode
//   Inst_Count                       retired-instruction counter (wraps)
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic             CLK,
    input  logic             Rst,
    input  logic [5:0]       Op,
    input  logic             Zero,
    input  logic             Mem_Ready,
    output logic             PCEn,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       State,
    output logic             Illegal,
    output logic [CNT_W-1:0] Inst_Count
);

    // Held as a plain 4-bit vector so unused codes remain representable
    // and can be steered back to S_RESET.
    logic [3:0]       state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             retire;
    ctrl_t            ctrl;

    always_ff @(posedge CLK or negedge Rst) begin
        if (!Rst) begin
            state_reg <= S_RESET;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = S_RESET;
        case (state_reg)
            S_RESET:  state_next = S_FETCH;
            S_FETCH:  state_next = Mem_Ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_RTYPE:     state_next = S_EXEC;
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_ADDI:      state_next = S_ADDIEX;
                    default:      state_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR: state_next = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_next = Mem_Ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_next = Mem_Ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_next = S_RWB;
            S_ADDIEX: state_next = S_ADDIWB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_RESET;
        endcase
    end

    // An instruction retires on the edge that leaves its final state.
    always_comb begin
        retire = 1'b0;
        case (state_reg)
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: retire = 1'b1;
            S_MEMWR: retire = Mem_Ready;
            default: retire = 1'b0;
        endcase
        count_next = count_reg;
        if (retire) begin
            count_next = count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    mc_ctrl_decode u_decode (
        .state     (state_reg),
        .op        (Op),
        .mem_ready (Mem_Ready),
        .ctrl      (ctrl)
    );

    assign PCEn       = ctrl.pcwrite | (ctrl.branch & Zero);
    assign IorD       = ctrl.iord;
    assign MemRead    = ctrl.memread;
    assign MemWrite   = ctrl.memwrite;
    assign IRWrite    = ctrl.irwrite;
    assign MemtoReg   = ctrl.memtoreg;
    assign RegDst     = ctrl.regdst;
    assign RegWrite   = ctrl.regwrite;
    assign ALUSrcA    = ctrl.alusrca;
    assign ALUSrcB    = ctrl.alusrcb;
    assign ALUOp      = ctrl.aluop;
    assign PCSource   = ctrl.pcsource;
    assign Illegal    = ctrl.illegal;
    assign State      = state_reg;
    assign Inst_Count = count_reg;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed testbench for mc_control_fsm. Two instances: dut returns to fetch
// on an illegal opcode, dut_h parks in HALT.
module tb_mc_control_fsm;

    logic        CLK = 1'b0;
    logic        Rst, Rst_h;
    logic [5:0]  Op, Op_h;
    logic        Zero, Mem_Ready;

    logic        PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, Illegal;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic [3:0]  State;
    logic [31:0] Inst_Count;

    logic        PCEn_h, IorD_h, MemRead_h, MemWrite_h, IRWrite_h, MemtoReg_h, RegDst_h, RegWrite_h, ALUSrcA_h, Illegal_h;
    logic [1:0]  ALUSrcB_h, ALUOp_h, PCSource_h;
    logic [3:0]  State_h;
    logic [31:0] Inst_Count_h;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 CLK = ~CLK;

    mc_control_fsm #(.CNT_W(32), .ILLEGAL_HALT(1'b0)) dut (
        .CLK(CLK), .Rst(Rst), .Op(Op), .Zero(Zero), .Mem_Ready(Mem_Ready),
        .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .State(State),
        .Illegal(Illegal), .Inst_Count(Inst_Count)
    );

    mc_control_fsm #(.CNT_W(32), .ILLEGAL_HALT(1'b1)) dut_h (
        .CLK(CLK), .Rst(Rst_h), .Op(Op_h), .Zero(Zero), .Mem_Ready(Mem_Ready),
        .PCEn(PCEn_h), .IorD(IorD_h), .MemRead(MemRead_h), .MemWrite(MemWrite_h), .IRWrite(IRWrite_h),
        .MemtoReg(MemtoReg_h), .RegDst(RegDst_h), .RegWrite(RegWrite_h), .ALUSrcA(ALUSrcA_h),
        .ALUSrcB(ALUSrcB_h), .ALUOp(ALUOp_h), .PCSource(PCSource_h), .State(State_h),
        .Illegal(Illegal_h), .Inst_Count(Inst_Count_h)
    );

    // Observed control word of each instance, field order matching mk().
    logic [15:0] word, word_h;
    assign word   = {PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                     ALUSrcA, ALUSrcB, ALUOp, PCSource, Illegal};
    assign word_h = {PCEn_h, IorD_h, MemRead_h, MemWrite_h, IRWrite_h, MemtoReg_h, RegDst_h,
                     RegWrite_h, ALUSrcA_h, ALUSrcB_h, ALUOp_h, PCSource_h, Illegal_h};

    function automatic logic [15:0] mk(input logic pcen, iord, mrd, mwr, irw, m2r, rdst, rw, srca,
                                       input logic [1:0] srcb, aop, psrc, input logic ill);
        return {pcen, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, psrc, ill};
    endfunction

    // Hand-derived expected words per state.
    localparam logic [15:0] W_ZERO = 16'h0000;
    logic [15:0] w_fetch_rdy, w_fetch_wait, w_decode, w_decode_ill, w_memadr, w_memrd, w_memwb;
    logic [15:0] w_memwr, w_exec, w_rwb, w_br_z1, w_br_z0, w_jump, w_addiex, w_addiwb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        //                 pcen iord mrd mwr irw m2r rdst rw srca srcb   aluop  psrc  ill
        w_fetch_rdy  = mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
        w_fetch_wait = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
        w_decode     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0);
        w_decode_ill = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 1);
        w_memadr     = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
        w_memrd      = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        w_memwb      = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
        w_memwr      = mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        w_exec       = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0);
        w_rwb        = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0);
        w_br_z1      = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
        w_br_z0      = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
        w_jump       = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0);
        w_addiex     = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
        w_addiwb     = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);

        Rst = 1'b1; Rst_h = 1'b0; Op = 6'b100011; Op_h = 6'h3F; Zero = 1'b0; Mem_Ready = 1'b1;

        // Reset pulse 10..20 ns
        #10 Rst = 1'b0;
        #9;
        chk("reset_state", 32'(State), 32'd0);
        chk("reset_word", 32'(word), 32'(W_ZERO));
        chk("reset_count", Inst_Count, 32'd0);
        #1 Rst = 1'b1;
        tick();
        chk("first_fetch_state", 32'(State), 32'd1);
        chk("first_fetch_word", 32'(word), 32'(w_fetch_rdy));

        // FETCH waiting on memory
        Mem_Ready = 1'b0; #1;
        chk("fetch_wait_word", 32'(word), 32'(w_fetch_wait));
        tick();
        chk("fetch_wait_state", 32'(State), 32'd1);
        Mem_Ready = 1'b1; #1;
        chk("fetch_rdy_word", 32'(word), 32'(w_fetch_rdy));

        // lw: 1,2,3,4,5,1
        Op = 6'b100011;
        tick(); chk("lw_s2", 32'(State), 32'd2); chk("lw_decode_word", 32'(word), 32'(w_decode));
        tick(); chk("lw_s3", 32'(State), 32'd3); chk("lw_memadr_word", 32'(word), 32'(w_memadr));
        tick(); chk("lw_s4", 32'(State), 32'd4); chk("lw_memrd_word", 32'(word), 32'(w_memrd));
        tick(); chk("lw_s5", 32'(State), 32'd5); chk("lw_memwb_word", 32'(word), 32'(w_memwb));
        chk("lw_count_before", Inst_Count, 32'd0);
        tick(); chk("lw_s1", 32'(State), 32'd1); chk("lw_count_after", Inst_Count, 32'd1);

        // sw with two wait cycles in MEMWR
        Op = 6'b101011;
        tick(); chk("sw_s2", 32'(State), 32'd2);
        tick(); chk("sw_s3", 32'(State), 32'd3);
        tick(); chk("sw_s6a", 32'(State), 32'd6); chk("sw_word_a", 32'(word), 32'(w_memwr));
        Mem_Ready = 1'b0;
        tick(); chk("sw_s6b", 32'(State), 32'd6); chk("sw_word_b", 32'(word), 32'(w_memwr));
        tick(); chk("sw_s6c", 32'(State), 32'd6); chk("sw_word_c", 32'(word), 32'(w_memwr));
        chk("sw_count_wait", Inst_Count, 32'd1);
        Mem_Ready = 1'b1;
        tick(); chk("sw_s1", 32'(State), 32'd1); chk("sw_count_after", Inst_Count, 32'd2);

        // R-type
        Op = 6'b000000;
        tick(); chk("r_s2", 32'(State), 32'd2);
        tick(); chk("r_s7", 32'(State), 32'd7); chk("r_exec_word", 32'(word), 32'(w_exec));
        tick(); chk("r_s8", 32'(State), 32'd8); chk("r_rwb_word", 32'(word), 32'(w_rwb));
        tick(); chk("r_s1", 32'(State), 32'd1); chk("r_count", Inst_Count, 32'd3);

        // beq, Zero both ways in BRANCH
        Op = 6'b000100;
        tick(); chk("beq_s2", 32'(State), 32'd2);
        tick(); chk("beq_s9", 32'(State), 32'd9);
        Zero = 1'b1; #1; chk("beq_z1_word", 32'(word), 32'(w_br_z1));
        Zero = 1'b0; #1; chk("beq_z0_word", 32'(word), 32'(w_br_z0));
        tick(); chk("beq_s1", 32'(State), 32'd1); chk("beq_count", Inst_Count, 32'd4);

        // j
        Op = 6'b000010;
        tick(); chk("j_s2", 32'(State), 32'd2);
        tick(); chk("j_s10", 32'(State), 32'd10); chk("j_word", 32'(word), 32'(w_jump));
        tick(); chk("j_s1", 32'(State), 32'd1); chk("j_count", Inst_Count, 32'd5);

        // addi
        Op = 6'b001000;
        tick(); chk("addi_s2", 32'(State), 32'd2);
        tick(); chk("addi_s11", 32'(State), 32'd11); chk("addi_ex_word", 32'(word), 32'(w_addiex));
        tick(); chk("addi_s12", 32'(State), 32'd12); chk("addi_wb_word", 32'(word), 32'(w_addiwb));
        tick(); chk("addi_s1", 32'(State), 32'd1); chk("addi_count", Inst_Count, 32'd6);

        // illegal opcode, return-to-fetch instance
        Op = 6'h3F;
        tick(); chk("ill_s2", 32'(State), 32'd2); chk("ill_decode_word", 32'(word), 32'(w_decode_ill));
        tick(); chk("ill_s1", 32'(State), 32'd1); chk("ill_pulse_end", 32'(Illegal), 32'd0);
        chk("ill_count", Inst_Count, 32'd6);

        // asynchronous reset while a store is pending
        Op = 6'b101011;
        tick(); tick(); tick();
        chk("arst_in_memwr", 32'(State), 32'd6); chk("arst_memwrite_hi", 32'(MemWrite), 32'd1);
        Mem_Ready = 1'b0;
        #2 Rst = 1'b0;
        #1;
        chk("arst_memwrite_lo", 32'(MemWrite), 32'd0);
        chk("arst_state", 32'(State), 32'd0);
        chk("arst_word", 32'(word), 32'(W_ZERO));
        chk("arst_count", Inst_Count, 32'd0);
        Rst = 1'b1; Mem_Ready = 1'b1;
        tick(); chk("arst_refetch", 32'(State), 32'd1);

        // illegal opcode, halting instance
        Rst_h = 1'b1;
        tick(); chk("halt_s1", 32'(State_h), 32'd1);
        tick(); chk("halt_s2", 32'(State_h), 32'd2); chk("halt_illegal", 32'(Illegal_h), 32'd1);
        tick(); chk("halt_s13", 32'(State_h), 32'd13); chk("halt_word", 32'(word_h), 32'(W_ZERO));
        tick(); tick();
        chk("halt_held", 32'(State_h), 32'd13);
        chk("halt_count", Inst_Count_h, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
